// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed 4-digit common-anode 7-segment driver. Scans sec1, sec10,
//   min1 and min10 in turn, one digit per REFRESH_DIV-cycle slot, and blanks
//   the selected digit pair at a BLINK_DIV-cycle rate while adj is high.
//   Optional macro DP_COLON_EN: lights the decimal point on the min1 digit
//   (an=4'b1011) as a minutes/seconds separator; otherwise dp stays off.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] min10,
    input  logic [3:0] min1,
    input  logic [3:0] sec10,
    input  logic [3:0] sec1,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef enum logic {VISIBLE = 1'b0, BLANK = 1'b1} phase_t;

    logic [RW-1:0] rcnt;
    logic [BW-1:0] bcnt;
    logic [1:0]    idx;
    phase_t        phase;
    logic [3:0]    digit;
    logic          in_sel_pair;
    logic [6:0]    seg_next;
    logic          slot_load;

    // BCD to active-low {g,f,e,d,c,b,a}; non-decimal codes show nothing
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        case (v)
            4'd0:    bcd_to_seg = 7'b1000000;
            4'd1:    bcd_to_seg = 7'b1111001;
            4'd2:    bcd_to_seg = 7'b0100100;
            4'd3:    bcd_to_seg = 7'b0110000;
            4'd4:    bcd_to_seg = 7'b0011001;
            4'd5:    bcd_to_seg = 7'b0010010;
            4'd6:    bcd_to_seg = 7'b0000010;
            4'd7:    bcd_to_seg = 7'b1111000;
            4'd8:    bcd_to_seg = 7'b0000000;
            4'd9:    bcd_to_seg = 7'b0010000;
            default: bcd_to_seg = SEG_OFF;
        endcase
    endfunction

    assign slot_load = (rcnt == R_LAST);

    // Select the digit for the current index and apply blink blanking to the chosen pair
    always_comb begin
        digit = sec1;
        case (idx)
            2'd0: digit = sec1;
            2'd1: digit = sec10;
            2'd2: digit = min1;
            2'd3: digit = min10;
            default: digit = sec1;
        endcase
        // sel=1 targets indices 0/1 (seconds), sel=0 targets indices 2/3 (minutes)
        in_sel_pair = (idx[1] != sel);
        seg_next    = ((phase == BLANK) && in_sel_pair) ? SEG_OFF : bcd_to_seg(digit);
    end

    // Slot timer: load anode/segment registers at the end of each slot, then advance the digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt <= '0;
            idx  <= 2'd0;
            an   <= 4'b1111;
            seg  <= SEG_OFF;
        end else if (slot_load) begin
            rcnt <= '0;
            an   <= ~(4'b0001 << idx);
            seg  <= seg_next;
            idx  <= idx + 2'd1;
        end else begin
            rcnt <= rcnt + RW'(1);
        end
    end

    // Blink timer: runs only in adjust mode, toggling the phase on every wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt  <= '0;
            phase <= VISIBLE;
        end else if (!adj) begin
            bcnt  <= '0;
            phase <= VISIBLE;
        end else if (bcnt == B_LAST) begin
            bcnt  <= '0;
            phase <= (phase == VISIBLE) ? BLANK : VISIBLE;
        end else begin
            bcnt <= bcnt + BW'(1);
        end
    end

`ifdef DP_COLON_EN
    // Colon: decimal point lit only for the min1 slot, independent of blinking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp <= 1'b1;
        end else if (slot_load) begin
            dp <= (idx != 2'd2);
        end
    end
`else
    assign dp = 1'b1;
`endif

endmodule
